fft_frame_feeder: RTL and testbench



---
 rtl/fft_feeder_pkg.sv | 29 ++
 rtl/fft_feeder_out_reg.sv | 38 +++
 rtl/fft_frame_feeder.sv | 151 +++++++++++++++
 tb/tb_fft_frame_feeder.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_feeder_pkg.sv
// Shared types and helpers for the FFT frame feeder: state encoding, frame-size limits
// and the complex-sample packer.
package fft_feeder_pkg;

  localparam int unsigned FRAME_LOG2_MIN = 3;
  localparam int unsigned FRAME_LOG2_MAX = 12;
  localparam int unsigned CPLX_MAX_W     = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    END  = 2'd2,
    PAD  = 2'd3
  } feeder_state_e;

  // Returns {im, re} in the low 2*out_w bits: re sign-extended from smp_w bits, im = 0.
  function automatic logic [2*CPLX_MAX_W-1:0] pack_cplx(
    input logic [CPLX_MAX_W-1:0] smp,
    input int unsigned           smp_w,
    input int unsigned           out_w
  );
    logic [CPLX_MAX_W-1:0]   re;
    logic [2*CPLX_MAX_W-1:0] mask;
    re   = CPLX_MAX_W'($signed(smp << (CPLX_MAX_W - smp_w)) >>> (CPLX_MAX_W - smp_w));
    mask = ((2*CPLX_MAX_W)'(1) << out_w) - (2*CPLX_MAX_W)'(1);
    return {CPLX_MAX_W'(0), re} & mask;
  endfunction

endpackage

// File: rtl/fft_feeder_out_reg.sv
// Single-stage valid/ready holding register between the feeder and the FFT core.
module fft_feeder_out_reg #(
  parameter int unsigned W = 32
) (
  input  logic         rd_clk,
  input  logic         rd_rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         load_sof,
  input  logic         load_last,
  input  logic         m_tready,
  output logic [W-1:0] m_tdata,
  output logic         m_tvalid,
  output logic         m_tsof,
  output logic         m_tlast,
  output logic         accept_c
);

  assign accept_c = ~m_tvalid | m_tready;

  // load is only raised while accept_c is high, so a stalled beat is never overwritten
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      m_tdata  <= '0;
      m_tvalid <= 1'b0;
      m_tsof   <= 1'b0;
      m_tlast  <= 1'b0;
    end else if (load) begin
      m_tdata  <= load_data;
      m_tvalid <= 1'b1;
      m_tsof   <= load_sof;
      m_tlast  <= load_last;
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/fft_frame_feeder.sv
// Drains the prefetch FIFO, selects one audio channel and emits fixed-length complex frames
// to the FFT core. Define FFT_FRAME_STATS_EN to add frame/underrun/pad counters.
module fft_frame_feeder
  import fft_feeder_pkg::*;
#(
  parameter int unsigned FRAME_LOG2 = 10,
  parameter int unsigned IN_W       = 32,
  parameter int unsigned SMP_W      = 16,
  parameter int unsigned OUT_W      = 16
) (
  input  logic                rd_clk,
  input  logic                rd_rst,
  input  logic                en,
  input  logic                ch_sel,
  input  logic                abort,
  input  logic [IN_W-1:0]     fifo_rd_data,
  input  logic                fifo_rd_vld,
  output logic                fifo_rd_en,
  output logic [2*OUT_W-1:0]  m_tdata,
  output logic                m_tvalid,
  input  logic                m_tready,
  output logic                m_tsof,
  output logic                m_tlast,
  output logic                busy
`ifdef FFT_FRAME_STATS_EN
  ,
  output logic [15:0]         frame_cnt,
  output logic [15:0]         underrun_cnt,
  output logic [15:0]         pad_cnt
`endif
);

  localparam int unsigned N      = 32'(1) << FRAME_LOG2;
  localparam int unsigned DATA_W = 2 * OUT_W;
  localparam logic [FRAME_LOG2-1:0] CNT_LAST = FRAME_LOG2'(N - 1);

  if (FRAME_LOG2 < FRAME_LOG2_MIN || FRAME_LOG2 > FRAME_LOG2_MAX ||
      IN_W != 2 * SMP_W || OUT_W < SMP_W || OUT_W > CPLX_MAX_W) begin : g_bad_param
    $error("fft_frame_feeder: illegal parameter set");
  end

  feeder_state_e          state;
  logic [FRAME_LOG2-1:0]  cnt;
  logic                   ch_sel_q;
  logic                   accept_c;
  logic                   pop_c;
  logic                   load_c;
  logic                   load_sof_c;
  logic                   load_last_c;
  logic [DATA_W-1:0]      load_data_c;
  logic [SMP_W-1:0]       smp_c;

  // Ready to the FIFO never looks at fifo_rd_vld, so no loop forms through the FIFO
  assign fifo_rd_en = (state == RUN) && accept_c;
  assign pop_c      = fifo_rd_en && fifo_rd_vld;
  assign busy       = (state != IDLE);
  assign smp_c      = ch_sel_q ? fifo_rd_data[IN_W-1:SMP_W] : fifo_rd_data[SMP_W-1:0];

  always_comb begin
    load_c      = 1'b0;
    load_data_c = '0;
    load_sof_c  = (cnt == '0);
    load_last_c = (cnt == CNT_LAST);
    case (state)
      RUN: begin
        load_c      = pop_c;
        load_data_c = DATA_W'(pack_cplx(CPLX_MAX_W'(smp_c), SMP_W, OUT_W));
      end
      PAD:     load_c = accept_c && (cnt != '0);
      default: ;
    endcase
  end

  // Frame sequencer; cnt is the index of the next beat to be loaded
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state    <= IDLE;
      cnt      <= '0;
      ch_sel_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            ch_sel_q <= ch_sel;
            cnt      <= '0;
            state    <= RUN;
          end
        end
        RUN: begin
          if (pop_c) cnt <= cnt + FRAME_LOG2'(1);
          if (pop_c && cnt == CNT_LAST) begin
            state <= END;
          end else if (abort) begin
            state <= (!pop_c && cnt == '0) ? IDLE : PAD;
          end
        end
        END: begin
          if (accept_c) begin
            if (en) begin
              ch_sel_q <= ch_sel;
              state    <= RUN;
            end else begin
              state    <= IDLE;
            end
          end
        end
        PAD: begin
          // cnt wraps to 0 once the last zero beat is loaded; leave when it is taken
          if (accept_c) begin
            if (cnt == '0) state <= IDLE;
            else           cnt   <= cnt + FRAME_LOG2'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  fft_feeder_out_reg #(
    .W (DATA_W)
  ) u_out_reg (
    .rd_clk    (rd_clk),
    .rd_rst    (rd_rst),
    .load      (load_c),
    .load_data (load_data_c),
    .load_sof  (load_sof_c),
    .load_last (load_last_c),
    .m_tready  (m_tready),
    .m_tdata   (m_tdata),
    .m_tvalid  (m_tvalid),
    .m_tsof    (m_tsof),
    .m_tlast   (m_tlast),
    .accept_c  (accept_c)
  );

`ifdef FFT_FRAME_STATS_EN
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      frame_cnt    <= '0;
      underrun_cnt <= '0;
      pad_cnt      <= '0;
    end else begin
      if (m_tvalid && m_tready && m_tlast) frame_cnt <= frame_cnt + 16'd1;
      if (state == RUN && fifo_rd_en && !fifo_rd_vld && underrun_cnt != 16'hFFFF)
        underrun_cnt <= underrun_cnt + 16'd1;
      if (state == PAD && load_c && pad_cnt != 16'hFFFF) pad_cnt <= pad_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Self-checking bench for fft_frame_feeder (N=8, OUT_W=20 so sign extension is visible).
// Honours FFT_FRAME_STATS_EN when the design is built with it.
`timescale 1ns/1ps
module tb_fft_frame_feeder;

  localparam int unsigned FRAME_LOG2 = 3;
  localparam int unsigned N          = 8;
  localparam int unsigned OUT_W      = 20;
  localparam int unsigned DW         = 2 * OUT_W;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sof;
    logic          last;
  } beat_t;

  logic          rd_clk = 1'b0;
  logic          rd_rst, en, ch_sel, abort, m_tready;
  logic          fifo_rd_vld, fifo_rd_en, m_tvalid, m_tsof, m_tlast, busy;
  logic [31:0]   fifo_rd_data;
  logic [DW-1:0] m_tdata;
`ifdef FFT_FRAME_STATS_EN
  logic [15:0]   frame_cnt, underrun_cnt, pad_cnt;
`endif

  // FIFO model: array plus monotonic pointers; rd_ptr doubles as the pop counter
  logic [31:0] mem [0:63];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  logic        vld_gate;

  beat_t       cap [0:255];
  int          cap_n = 0;
  int          stall_viol = 0;
  logic        stall_prev = 1'b0;
  beat_t       stall_beat;

  logic [31:0] fw [0:15];
  beat_t       exp_q [$];
  int          checks = 0;
  int          failures = 0;

  fft_frame_feeder #(
    .FRAME_LOG2 (FRAME_LOG2),
    .IN_W       (32),
    .SMP_W      (16),
    .OUT_W      (OUT_W)
  ) dut (
    .rd_clk       (rd_clk),
    .rd_rst       (rd_rst),
    .en           (en),
    .ch_sel       (ch_sel),
    .abort        (abort),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_vld  (fifo_rd_vld),
    .fifo_rd_en   (fifo_rd_en),
    .m_tdata      (m_tdata),
    .m_tvalid     (m_tvalid),
    .m_tready     (m_tready),
    .m_tsof       (m_tsof),
    .m_tlast      (m_tlast),
    .busy         (busy)
`ifdef FFT_FRAME_STATS_EN
    ,
    .frame_cnt    (frame_cnt),
    .underrun_cnt (underrun_cnt),
    .pad_cnt      (pad_cnt)
`endif
  );

  always #5 rd_clk = ~rd_clk;

  assign fifo_rd_vld  = vld_gate && (wr_ptr != rd_ptr);
  assign fifo_rd_data = mem[rd_ptr[5:0]];

  always @(posedge rd_clk) begin
    if (fifo_rd_en && fifo_rd_vld) rd_ptr <= rd_ptr + 1;
  end

  // Capture accepted beats and flag any change of a stalled beat
  always @(posedge rd_clk) begin
    if (rd_rst) begin
      stall_prev <= 1'b0;
    end else begin
      if (m_tvalid && m_tready) begin
        cap[cap_n[7:0]] <= {m_tdata, m_tsof, m_tlast};
        cap_n <= cap_n + 1;
      end
      if (stall_prev && (!m_tvalid || stall_beat !== {m_tdata, m_tsof, m_tlast}))
        stall_viol <= stall_viol + 1;
      stall_prev <= m_tvalid && !m_tready;
      stall_beat <= {m_tdata, m_tsof, m_tlast};
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired: got timeout, required completion (checks=%0d)", checks);
    $fatal(1);
  end

  // Reference: selected 16-bit channel sign-extended into re, im = 0
  function automatic logic [DW-1:0] ref_sample(input logic [31:0] w, input logic sel);
    logic signed [15:0] s;
    int                 v;
    logic [OUT_W-1:0]   re;
    s  = sel ? w[31:16] : w[15:0];
    v  = s;
    re = v[OUT_W-1:0];
    return {{OUT_W{1'b0}}, re};
  endfunction

  // One frame of N beats: n_real FIFO samples, zero padding for the rest
  function automatic void model_frame(input int first, input int n_real, input logic sel);
    beat_t b;
    for (int i = 0; i < int'(N); i++) begin
      b.data = (i < n_real) ? ref_sample(fw[first + i], sel) : '0;
      b.sof  = (i == 0);
      b.last = (i == int'(N) - 1);
      exp_q.push_back(b);
    end
  endfunction

  task automatic tick();
    @(negedge rd_clk);
  endtask

  task automatic push(input logic [31:0] w);
    mem[wr_ptr[5:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic reset_dut();
    rd_rst = 1'b1; en = 1'b0; abort = 1'b0; m_tready = 1'b1; vld_gate = 1'b1;
    tick(); tick();
    rd_rst = 1'b0;
    wr_ptr = rd_ptr;
    exp_q.delete();
  endtask

  task automatic wait_idle(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (!busy && !m_tvalid) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    rd_rst = 1'b1; en = 1'b1; ch_sel = 1'b1; abort = 1'b0; m_tready = 1'b1; vld_gate = 1'b1;
    push(32'h1234_5678);
    tick(); tick();
    checks++; if (m_tvalid !== 1'b0) begin failures++; $display("FAIL reset_tvalid got %b want 0", m_tvalid); end
    checks++; if (m_tsof !== 1'b0 || m_tlast !== 1'b0) begin failures++; $display("FAIL reset_sof_last got %b%b want 00", m_tsof, m_tlast); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (fifo_rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en got %b want 0", fifo_rd_en); end
    checks++; if (m_tdata !== '0) begin failures++; $display("FAIL reset_tdata got %h want 0", m_tdata); end
`ifdef FFT_FRAME_STATS_EN
    checks++; if ({frame_cnt, underrun_cnt, pad_cnt} !== 48'd0) begin failures++; $display("FAIL reset_stats got %h want 0", {frame_cnt, underrun_cnt, pad_cnt}); end
`endif
    en = 1'b0;
    rd_rst = 1'b0;
    wr_ptr = rd_ptr;
  endtask

  task automatic test_single_frame();
    int base, pbase; bit found, ok;
    reset_dut();
    for (int i = 0; i < 8; i++) begin fw[i] = 32'h0001_8000; push(fw[i]); end
    ch_sel = 1'b0; base = cap_n; pbase = rd_ptr;
    en = 1'b1; tick(); en = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (fifo_rd_en && fifo_rd_vld) begin found = 1'b1; break; end
      tick();
    end
    tick();
    checks++;
    if (!found || m_tvalid !== 1'b1 || m_tsof !== 1'b1 || m_tdata !== ref_sample(fw[0], 1'b0)) begin
      failures++; $display("FAIL single_latency got vld=%b sof=%b data=%h want 1 1 %h", m_tvalid, m_tsof, m_tdata, ref_sample(fw[0], 1'b0));
    end
    wait_idle(60, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_idle got busy=%b want 0", busy); end
    model_frame(0, 8, 1'b0);
    checks++; if (cap_n - base != exp_q.size()) begin failures++; $display("FAIL single_count got %0d want %0d", cap_n - base, exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (cap[base + i] !== exp_q[i]) begin failures++; $display("FAIL single_beat%0d got %h want %h", i, cap[base + i], exp_q[i]); end
    end
    checks++; if (rd_ptr - pbase != 8) begin failures++; $display("FAIL single_pops got %0d want 8", rd_ptr - pbase); end
`ifdef FFT_FRAME_STATS_EN
    checks++; if (frame_cnt !== 16'd1 || pad_cnt !== 16'd0) begin failures++; $display("FAIL single_stats got frames=%0d pads=%0d want 1 0", frame_cnt, pad_cnt); end
`endif
  endtask

  task automatic test_back_to_back();
    int base, pbase, sbase; bit ok;
    reset_dut();
    for (int i = 0; i < 16; i++) begin fw[i] = $urandom; push(fw[i]); end
    base = cap_n; pbase = rd_ptr; sbase = stall_viol;
    ch_sel = 1'b1; en = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      m_tready = (k % 2 == 0);
      if (rd_ptr - pbase >= 1) ch_sel = 1'b0;
      if (rd_ptr - pbase >= 9) en = 1'b0;
      if (rd_ptr - pbase >= 16 && !busy && !m_tvalid) begin ok = 1'b1; break; end
      tick();
    end
    m_tready = 1'b1; en = 1'b0;
    checks++; if (!ok) begin failures++; $display("FAIL b2b_done got busy=%b pops=%0d want idle 16", busy, rd_ptr - pbase); end
    model_frame(0, 8, 1'b1);
    model_frame(8, 8, 1'b0);
    checks++; if (cap_n - base != exp_q.size()) begin failures++; $display("FAIL b2b_count got %0d want %0d", cap_n - base, exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (cap[base + i] !== exp_q[i]) begin failures++; $display("FAIL b2b_beat%0d got %h want %h", i, cap[base + i], exp_q[i]); end
    end
    checks++; if (rd_ptr - pbase != 16 || wr_ptr != rd_ptr) begin failures++; $display("FAIL b2b_pops got %0d want 16", rd_ptr - pbase); end
    checks++; if (stall_viol != sbase) begin failures++; $display("FAIL b2b_stall_hold got %0d changes want 0", stall_viol - sbase); end
`ifdef FFT_FRAME_STATS_EN
    checks++; if (frame_cnt !== 16'd2) begin failures++; $display("FAIL b2b_frame_cnt got %0d want 2", frame_cnt); end
`endif
  endtask

  task automatic test_underrun();
    int base, pbase, low; bit gap_done, ok; logic sel;
    reset_dut();
    sel = 1'($urandom_range(0, 1));
    for (int i = 0; i < 8; i++) begin fw[i] = $urandom; push(fw[i]); end
    base = cap_n; pbase = rd_ptr; low = 0; gap_done = 1'b0; ok = 1'b0;
    ch_sel = sel; en = 1'b1; tick(); en = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (!gap_done && rd_ptr - pbase == 4) begin
        vld_gate = 1'b0;
        repeat (5) begin
          tick();
          if (!m_tvalid && cap_n - base == 4) low++;
        end
        vld_gate = 1'b1; gap_done = 1'b1;
        tick();
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== ref_sample(fw[4], sel)) begin
          failures++; $display("FAIL underrun_resume got vld=%b data=%h want 1 %h", m_tvalid, m_tdata, ref_sample(fw[4], sel));
        end
      end
      if (rd_ptr - pbase == 8 && !busy && !m_tvalid) begin ok = 1'b1; break; end
      tick();
    end
    checks++; if (!ok) begin failures++; $display("FAIL underrun_done got busy=%b want 0", busy); end
    checks++; if (low != 5) begin failures++; $display("FAIL underrun_gap got %0d want 5", low); end
    model_frame(0, 8, sel);
    checks++; if (cap_n - base != exp_q.size()) begin failures++; $display("FAIL underrun_count got %0d want %0d", cap_n - base, exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (cap[base + i] !== exp_q[i]) begin failures++; $display("FAIL underrun_beat%0d got %h want %h", i, cap[base + i], exp_q[i]); end
    end
`ifdef FFT_FRAME_STATS_EN
    checks++; if (underrun_cnt !== 16'd5) begin failures++; $display("FAIL underrun_cnt got %0d want 5", underrun_cnt); end
`endif
  endtask

  task automatic test_abort_pad();
    int base, pbase; bit found, ok; logic sel;
    reset_dut();
    sel = 1'($urandom_range(0, 1));
    for (int i = 0; i < 8; i++) fw[i] = $urandom;
    for (int i = 0; i < 3; i++) push(fw[i]);
    base = cap_n; pbase = rd_ptr;
    ch_sel = sel; en = 1'b1; tick(); en = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (cap_n - base == 3) begin found = 1'b1; break; end
      tick();
    end
    checks++; if (!found) begin failures++; $display("FAIL abort_pad_reach got %0d beats want 3", cap_n - base); end
    abort = 1'b1; tick(); abort = 1'b0;
    for (int i = 3; i < 8; i++) push(fw[i]);
    wait_idle(60, ok);
    checks++; if (!ok) begin failures++; $display("FAIL abort_pad_idle got busy=%b want 0", busy); end
    model_frame(0, 3, sel);
    checks++; if (cap_n - base != exp_q.size()) begin failures++; $display("FAIL abort_pad_count got %0d want %0d", cap_n - base, exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (cap[base + i] !== exp_q[i]) begin failures++; $display("FAIL abort_pad_beat%0d got %h want %h", i, cap[base + i], exp_q[i]); end
    end
    checks++; if (rd_ptr - pbase != 3 || wr_ptr - rd_ptr != 5) begin failures++; $display("FAIL abort_pad_pops got %0d want 3", rd_ptr - pbase); end
`ifdef FFT_FRAME_STATS_EN
    checks++; if (pad_cnt !== 16'd5) begin failures++; $display("FAIL abort_pad_cnt got %0d want 5", pad_cnt); end
`endif
    wr_ptr = rd_ptr;
  endtask

  task automatic test_abort_idle();
    int base, pbase; bit seen;
    reset_dut();
    for (int i = 0; i < 4; i++) push($urandom);
    base = cap_n; pbase = rd_ptr;
    vld_gate = 1'b0; ch_sel = 1'b0;
    en = 1'b1; tick(); en = 1'b0;
    abort = 1'b1; tick(); abort = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_idle_busy got %b want 0", busy); end
    vld_gate = 1'b1; seen = 1'b0;
    repeat (6) begin tick(); if (m_tvalid) seen = 1'b1; end
    checks++; if (seen || cap_n != base) begin failures++; $display("FAIL abort_idle_tvalid got %b want 0", seen); end
    checks++; if (rd_ptr != pbase || wr_ptr - rd_ptr != 4) begin failures++; $display("FAIL abort_idle_fifo got pops=%0d level=%0d want 0 4", rd_ptr - pbase, wr_ptr - rd_ptr); end
    wr_ptr = rd_ptr;
  endtask

  task automatic test_reset_midframe();
    int base, pbase; bit found, ok; logic sel;
    reset_dut();
    for (int i = 0; i < 8; i++) push($urandom);
    pbase = rd_ptr;
    ch_sel = 1'b1; en = 1'b1; tick(); en = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (rd_ptr - pbase == 5) begin found = 1'b1; break; end
      tick();
    end
    rd_rst = 1'b1; tick();
    checks++;
    if (!found || {m_tvalid, m_tsof, m_tlast, busy, fifo_rd_en} !== 5'b0 || m_tdata !== '0) begin
      failures++; $display("FAIL midreset_outputs got vld=%b sof=%b last=%b busy=%b rd_en=%b data=%h want all 0",
                           m_tvalid, m_tsof, m_tlast, busy, fifo_rd_en, m_tdata);
    end
    rd_rst = 1'b0;
    wr_ptr = rd_ptr;
    sel = 1'($urandom_range(0, 1));
    for (int i = 0; i < 8; i++) begin fw[i] = $urandom; push(fw[i]); end
    base = cap_n;
    ch_sel = sel; en = 1'b1; tick(); en = 1'b0;
    wait_idle(60, ok);
    checks++; if (!ok) begin failures++; $display("FAIL midreset_idle got busy=%b want 0", busy); end
    model_frame(0, 8, sel);
    checks++; if (cap_n - base != exp_q.size()) begin failures++; $display("FAIL midreset_count got %0d want %0d", cap_n - base, exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (cap[base + i] !== exp_q[i]) begin failures++; $display("FAIL midreset_beat%0d got %h want %h", i, cap[base + i], exp_q[i]); end
    end
  endtask

  task automatic test_random_frames();
    int base, pbase, sbase; bit ok; logic sel;
    reset_dut();
    sbase = stall_viol;
    for (int f = 0; f < 4; f++) begin
      exp_q.delete();
      sel = 1'($urandom_range(0, 1));
      for (int i = 0; i < 8; i++) begin fw[i] = $urandom; push(fw[i]); end
      base = cap_n; pbase = rd_ptr; ok = 1'b0;
      ch_sel = sel; en = 1'b1; tick(); en = 1'b0;
      for (int k = 0; k < 300; k++) begin
        m_tready = 1'($urandom_range(0, 1));
        vld_gate = ($urandom_range(0, 3) != 0);
        if (rd_ptr - pbase == 8 && !busy && !m_tvalid) begin ok = 1'b1; break; end
        tick();
      end
      m_tready = 1'b1; vld_gate = 1'b1;
      checks++; if (!ok) begin failures++; $display("FAIL rand%0d_done got busy=%b pops=%0d want idle 8", f, busy, rd_ptr - pbase); end
      model_frame(0, 8, sel);
      checks++; if (cap_n - base != exp_q.size()) begin failures++; $display("FAIL rand%0d_count got %0d want %0d", f, cap_n - base, exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (cap[base + i] !== exp_q[i]) begin failures++; $display("FAIL rand%0d_beat%0d got %h want %h", f, i, cap[base + i], exp_q[i]); end
      end
    end
    checks++; if (stall_viol != sbase) begin failures++; $display("FAIL rand_stall_hold got %0d changes want 0", stall_viol - sbase); end
`ifdef FFT_FRAME_STATS_EN
    checks++; if (frame_cnt !== 16'd4) begin failures++; $display("FAIL rand_frame_cnt got %0d want 4", frame_cnt); end
`endif
  endtask

  initial begin
    rd_rst = 1'b1; en = 1'b0; ch_sel = 1'b0; abort = 1'b0; m_tready = 1'b1; vld_gate = 1'b1;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_underrun();
    test_abort_pad();
    test_abort_idle();
    test_reset_midframe();
    test_random_frames();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
